rv32i_multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle RV32I decoder: a state machine that sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the same datapath control fields plus PC/IR write enables and request/ready handshakes toward instruction and data memory.
- Adds LUI/AUIPC decoding, illegal-opcode trapping, a memory-response timeout and a retired-instruction counter.
- Sits between the IR and a shared datapath (PC, IR, register unit, ALU, branch unit, data memory).

---
 rtl/rv32i_multicycle_control_if.sv | 22 ++
 rtl/rv32i_multicycle_control.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_control.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_multicycle_control_if.sv
// Request/ready handshake between the multicycle controller and the
// instruction and data memories.
interface rv32i_multicycle_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/rv32i_multicycle_control.sv
// Multicycle RV32I controller: sequences fetch/decode/execute/mem/writeback,
// traps on illegal opcodes and memory timeouts, and counts retired instructions.
module rv32i_multicycle_control #(
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int RETIRE_W        = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          OpCode,
    input  logic [2:0]          Funct3,
    input  logic [6:0]          Funct7,
    rv32i_multicycle_control_if.master mem,
    output logic                IRWr,
    output logic                PCWr,
    output logic [2:0]          ImmSrc,
    output logic                ALUASrc,
    output logic                ALUBSrc,
    output logic [3:0]          ALUOp,
    output logic [1:0]          RUDataWrSrc,
    output logic                RUWr,
    output logic [4:0]          BrOp,
    output logic                DMWr,
    output logic [2:0]          DMCtrl,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [RETIRE_W-1:0] retire_cnt;
    logic                trap_q;
    logic [1:0]          cause_q;
    logic                retire;
    logic                trap_set;
    logic [1:0]          trap_code;
    logic                timed_out;
    logic                fetch_req;
    logic                data_req;

    logic is_r, is_i, is_load, is_store, is_branch, is_jalr, is_jal, is_lui, is_auipc, legal;
    logic [2:0] alu_imm;
    logic       alu_a;
    logic       alu_b;
    logic [3:0] alu_op;
    logic       unused_funct7;

    assign is_r      = (OpCode == OP_R);
    assign is_i      = (OpCode == OP_I);
    assign is_load   = (OpCode == OP_LOAD);
    assign is_store  = (OpCode == OP_STORE);
    assign is_branch = (OpCode == OP_BRANCH);
    assign is_jalr   = (OpCode == OP_JALR);
    assign is_jal    = (OpCode == OP_JAL);
    assign is_lui    = (OpCode == OP_LUI);
    assign is_auipc  = (OpCode == OP_AUIPC);
    assign legal     = is_r | is_i | is_load | is_store | is_branch |
                       is_jalr | is_jal | is_lui | is_auipc;
    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    // Timeout fires on the wait cycle that would bring the count to the limit.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        alu_imm = 3'b000;
        alu_a   = 1'b0;
        alu_b   = 1'b0;
        alu_op  = 4'b0000;
        if (is_r) begin
            alu_op = {Funct7[5], Funct3};
        end else if (is_i) begin
            alu_b  = 1'b1;
            alu_op = (Funct3 == 3'b101) ? {Funct7[5], Funct3} : {1'b0, Funct3};
        end else if (is_load) begin
            alu_b = 1'b1;
        end else if (is_store) begin
            alu_imm = 3'b001;
            alu_b   = 1'b1;
        end else if (is_lui) begin
            alu_imm = 3'b010;
            alu_b   = 1'b1;
            alu_op  = 4'b1111;
        end else if (is_auipc) begin
            alu_imm = 3'b010;
            alu_a   = 1'b1;
            alu_b   = 1'b1;
        end else if (is_branch) begin
            alu_imm = 3'b101;
            alu_a   = 1'b1;
            alu_b   = 1'b1;
        end else if (is_jal) begin
            alu_imm = 3'b110;
            alu_a   = 1'b1;
            alu_b   = 1'b1;
        end else if (is_jalr) begin
            alu_b = 1'b1;
        end
    end

    // Everything stays at zero while reset is held, whatever the state register holds.
    always_comb begin
        fetch_req   = 1'b0;
        data_req    = 1'b0;
        IRWr        = 1'b0;
        PCWr        = 1'b0;
        ImmSrc      = 3'b000;
        ALUASrc     = 1'b0;
        ALUBSrc     = 1'b0;
        ALUOp       = 4'b0000;
        RUDataWrSrc = 2'b00;
        RUWr        = 1'b0;
        BrOp        = 5'b00000;
        DMWr        = 1'b0;
        DMCtrl      = 3'b000;
        next_state  = state;
        retire      = 1'b0;
        trap_set    = 1'b0;
        trap_code   = 2'b00;
        if (rst_n) begin
            if (state == EXECUTE || state == MEM || state == WB) begin
                ImmSrc  = alu_imm;
                ALUASrc = alu_a;
                ALUBSrc = alu_b;
                ALUOp   = alu_op;
            end
            case (state)
                FETCH: begin
                    fetch_req = 1'b1;
                    if (mem.imem_ready) begin
                        IRWr       = 1'b1;
                        next_state = DECODE;
                    end else if (timed_out) begin
                        next_state = TRAP;
                        trap_set   = 1'b1;
                        trap_code  = 2'b10;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        next_state = EXECUTE;
                    end else if (TRAP_ON_ILLEGAL) begin
                        next_state = TRAP;
                        trap_set   = 1'b1;
                        trap_code  = 2'b01;
                    end else begin
                        PCWr       = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                end
                EXECUTE: begin
                    if (is_branch) begin
                        BrOp       = {2'b01, Funct3};
                        PCWr       = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else if (is_jal || is_jalr) begin
                        RUWr        = 1'b1;
                        RUDataWrSrc = 2'b10;
                        BrOp        = 5'b10000;
                        PCWr        = 1'b1;
                        retire      = 1'b1;
                        next_state  = FETCH;
                    end else if (is_load || is_store) begin
                        next_state = MEM;
                    end else begin
                        next_state = WB;
                    end
                end
                MEM: begin
                    data_req = 1'b1;
                    DMCtrl   = Funct3;
                    DMWr     = is_store;
                    if (mem.dmem_ready) begin
                        if (is_store) begin
                            PCWr       = 1'b1;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end else begin
                            next_state = WB;
                        end
                    end else if (timed_out) begin
                        next_state = TRAP;
                        trap_set   = 1'b1;
                        trap_code  = 2'b11;
                    end
                end
                WB: begin
                    RUWr        = 1'b1;
                    RUDataWrSrc = is_load ? 2'b01 : 2'b00;
                    PCWr        = 1'b1;
                    retire      = 1'b1;
                    next_state  = FETCH;
                end
                TRAP: begin
                    next_state = TRAP;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

    // Any state change restarts the wait count, so FETCH and MEM always begin at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            retire_cnt <= '0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state <= next_state;
            if (retire) begin
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
            if (trap_set) begin
                trap_q  <= 1'b1;
                cause_q <= trap_code;
            end
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if ((fetch_req && !mem.imem_ready) || (data_req && !mem.dmem_ready)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign mem.imem_req = fetch_req;
    assign mem.dmem_req = data_req;
    assign trap         = rst_n & trap_q;
    assign trap_cause   = rst_n ? cause_q : 2'b00;
    assign retired      = rst_n ? retire_cnt : '0;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Bench for rv32i_multicycle_control: builds the expected per-cycle output trace
// of each instruction from the sequencing rules and compares cycle by cycle.
module tb_rv32i_multicycle_control;

    localparam int TO = 16;
    localparam int RW = 32;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_wr;
        logic       pc_wr;
        logic [2:0] imm_src;
        logic       a_src;
        logic       b_src;
        logic [3:0] alu_op;
        logic [1:0] wr_src;
        logic       ru_wr;
        logic [4:0] br_op;
        logic       dm_wr;
        logic [2:0] dm_ctrl;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        out_t vec;
        logic ir;
        logic dr;
        bit   retire;
    } step_t;

    localparam logic [6:0] LEGAL_OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                             7'h67, 7'h6F, 7'h37, 7'h17};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    OpCode;
    logic [2:0]    Funct3;
    logic [6:0]    Funct7;
    logic          IRWr, PCWr, ALUASrc, ALUBSrc, RUWr, DMWr, trap;
    logic [2:0]    ImmSrc, DMCtrl;
    logic [3:0]    ALUOp;
    logic [1:0]    RUDataWrSrc, trap_cause;
    logic [4:0]    BrOp;
    logic [RW-1:0] retired;

    rv32i_multicycle_control_if mem_bus ();

    rv32i_multicycle_control #(
        .TIMEOUT_CYCLES (TO),
        .RETIRE_W       (RW),
        .TRAP_ON_ILLEGAL(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OpCode     (OpCode),
        .Funct3     (Funct3),
        .Funct7     (Funct7),
        .mem        (mem_bus.master),
        .IRWr       (IRWr),
        .PCWr       (PCWr),
        .ImmSrc     (ImmSrc),
        .ALUASrc    (ALUASrc),
        .ALUBSrc    (ALUBSrc),
        .ALUOp      (ALUOp),
        .RUDataWrSrc(RUDataWrSrc),
        .RUWr       (RUWr),
        .BrOp       (BrOp),
        .DMWr       (DMWr),
        .DMCtrl     (DMCtrl),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    out_t obs_vec;
    assign obs_vec = {mem_bus.imem_req, mem_bus.dmem_req, IRWr, PCWr, ImmSrc, ALUASrc,
                      ALUBSrc, ALUOp, RUDataWrSrc, RUWr, BrOp, DMWr, DMCtrl, trap, trap_cause};

    step_t         trace [$];
    bit            trace_traps;
    int            vectors;
    int            miscompares;
    logic [RW-1:0] exp_retired;

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
    endfunction

    // ALU operand selection per instruction class, valid from EXECUTE onward.
    function automatic out_t alu_view(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        out_t o = '0;
        case (op)
            7'h33: o.alu_op = {f7[5], f3};
            7'h13: begin
                o.b_src  = 1'b1;
                o.alu_op = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
            end
            7'h03: o.b_src = 1'b1;
            7'h23: begin o.imm_src = 3'b001; o.b_src = 1'b1; end
            7'h37: begin o.imm_src = 3'b010; o.b_src = 1'b1; o.alu_op = 4'b1111; end
            7'h17: begin o.imm_src = 3'b010; o.a_src = 1'b1; o.b_src = 1'b1; end
            7'h63: begin o.imm_src = 3'b101; o.a_src = 1'b1; o.b_src = 1'b1; end
            7'h6F: begin o.imm_src = 3'b110; o.a_src = 1'b1; o.b_src = 1'b1; end
            7'h67: o.b_src = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic void push(out_t o, logic ir, logic dr, bit ret);
        step_t s;
        s.vec    = o;
        s.ir     = ir;
        s.dr     = dr;
        s.retire = ret;
        trace.push_back(s);
    endfunction

    function automatic void push_trap(logic [1:0] c);
        out_t o = '0;
        o.trap  = 1'b1;
        o.cause = c;
        for (int k = 0; k < 3; k++) push(o, rbit(), rbit(), 1'b0);
        trace_traps = 1'b1;
    endfunction

    // Expected cycle trace of one instruction; iw/dw are the memory wait cycles.
    function automatic void build_trace(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                        int iw, int dw);
        out_t o;
        int   n;
        trace.delete();
        trace_traps = 1'b0;
        n = (iw >= TO) ? TO : iw;
        for (int k = 0; k < n; k++) begin
            o = '0; o.imem_req = 1'b1;
            push(o, 1'b0, rbit(), 1'b0);
        end
        if (iw >= TO) begin
            push_trap(2'b10);
            return;
        end
        o = '0; o.imem_req = 1'b1; o.ir_wr = 1'b1;
        push(o, 1'b1, rbit(), 1'b0);
        o = '0;
        push(o, rbit(), rbit(), 1'b0);
        if (!is_legal(op)) begin
            push_trap(2'b01);
            return;
        end
        o = alu_view(op, f3, f7);
        case (op)
            7'h63: begin
                o.br_op = {2'b01, f3}; o.pc_wr = 1'b1;
                push(o, rbit(), rbit(), 1'b1);
            end
            7'h6F, 7'h67: begin
                o.ru_wr = 1'b1; o.wr_src = 2'b10; o.br_op = 5'b10000; o.pc_wr = 1'b1;
                push(o, rbit(), rbit(), 1'b1);
            end
            7'h03, 7'h23: begin
                push(o, rbit(), rbit(), 1'b0);
                o.dmem_req = 1'b1;
                o.dm_ctrl  = f3;
                o.dm_wr    = (op == 7'h23);
                n = (dw >= TO) ? TO : dw;
                for (int k = 0; k < n; k++) push(o, rbit(), 1'b0, 1'b0);
                if (dw >= TO) begin
                    push_trap(2'b11);
                    return;
                end
                if (op == 7'h23) begin
                    o.pc_wr = 1'b1;
                    push(o, rbit(), 1'b1, 1'b1);
                end else begin
                    push(o, rbit(), 1'b1, 1'b0);
                    o = alu_view(op, f3, f7);
                    o.ru_wr = 1'b1; o.wr_src = 2'b01; o.pc_wr = 1'b1;
                    push(o, rbit(), rbit(), 1'b1);
                end
            end
            default: begin
                push(o, rbit(), rbit(), 1'b0);
                o.ru_wr = 1'b1; o.pc_wr = 1'b1;
                push(o, rbit(), rbit(), 1'b1);
            end
        endcase
    endfunction

    task automatic check_output(input string tag, input out_t exp_vec, input logic [RW-1:0] exp_ret);
        vectors++;
        assert (obs_vec === exp_vec) else begin
            miscompares++;
            $error("[TB] FAIL %s outputs: observed %07h expected %07h", tag, obs_vec, exp_vec);
        end
        vectors++;
        assert (retired === exp_ret) else begin
            miscompares++;
            $error("[TB] FAIL %s retired: observed %0d expected %0d", tag, retired, exp_ret);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_trace(input string name, input int limit);
        for (int i = 0; i < trace.size() && i < limit; i++) begin
            mem_bus.imem_ready = trace[i].ir;
            mem_bus.dmem_ready = trace[i].dr;
            @(negedge clk);
            check_output($sformatf("%s[%0d]", name, i), trace[i].vec, exp_retired);
            if (trace[i].retire) exp_retired++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        mem_bus.imem_ready = rbit();
        mem_bus.dmem_ready = rbit();
        @(negedge clk);
        check_output({name, " reset"}, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_retired = '0;
    endtask

    task automatic apply_stimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input int iw, input int dw);
        OpCode = op;
        Funct3 = f3;
        Funct7 = f7;
        build_trace(op, f3, f7, iw, dw);
        run_trace(name, trace.size());
        if (trace_traps) do_reset({name, " exit"});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] op;
        int         iw;
        int         dw;
        rst_n = 1'b0;
        OpCode = '0;
        Funct3 = '0;
        Funct7 = '0;
        mem_bus.imem_ready = 1'b0;
        mem_bus.dmem_ready = 1'b0;
        vectors = 0;
        miscompares = 0;
        exp_retired = '0;

        do_reset("power-on");

        apply_stimulus("add",   7'h33, 3'b000, 7'h00, 1, 0);
        apply_stimulus("lw",    7'h03, 3'b010, 7'h00, 0, 3);
        apply_stimulus("beq",   7'h63, 3'b000, 7'h00, 0, 0);
        apply_stimulus("jal",   7'h6F, 3'b000, 7'h00, 0, 0);
        apply_stimulus("lui",   7'h37, 3'b101, 7'h20, 0, 0);
        apply_stimulus("sw",    7'h23, 3'b010, 7'h00, 2, 1);
        apply_stimulus("auipc", 7'h17, 3'b011, 7'h7F, 0, 0);
        apply_stimulus("jalr",  7'h67, 3'b000, 7'h00, 1, 0);
        apply_stimulus("srai",  7'h13, 3'b101, 7'h20, 0, 0);
        apply_stimulus("addi",  7'h13, 3'b000, 7'h20, 0, 0);
        apply_stimulus("sub",   7'h33, 3'b000, 7'h20, 0, 0);
        apply_stimulus("bne",   7'h63, 3'b001, 7'h00, 2, 0);

        apply_stimulus("illegal",    7'h7F, 3'b000, 7'h00, 0, 0);
        apply_stimulus("after-trap", 7'h33, 3'b111, 7'h00, 0, 0);
        apply_stimulus("lw-timeout", 7'h03, 3'b010, 7'h00, 0, TO);
        apply_stimulus("lw-edge",    7'h03, 3'b100, 7'h00, 0, TO - 1);
        apply_stimulus("sw-edge",    7'h23, 3'b001, 7'h00, TO - 1, TO - 1);
        apply_stimulus("if-timeout", 7'h33, 3'b000, 7'h00, TO, 0);

        apply_stimulus("pre-abort", 7'h13, 3'b000, 7'h00, 0, 0);
        OpCode = 7'h03;
        Funct3 = 3'b000;
        Funct7 = 7'h00;
        build_trace(7'h03, 3'b000, 7'h00, 0, 1);
        run_trace("lb-abort", trace.size() - 1);
        do_reset("lb-abort");
        apply_stimulus("post-abort", 7'h33, 3'b100, 7'h00, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end else begin
                op = LEGAL_OPS[$urandom_range(0, 8)];
            end
            iw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                              : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 12) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                              : int'($urandom_range(0, 3));
            apply_stimulus($sformatf("rand%0d", n), op, 3'($urandom), 7'($urandom), iw, dw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
